// File: rtl/com_sprom_rd_stream.sv
// com_sprom_rd_stream: sweeps a ROM address window and streams the words out with last-beat marking
module com_sprom_rd_stream #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEP = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LEN_W = $clog2(DEPTH + 1),
  localparam int CW = $clog2(FIFO_DEP + 1),
  localparam int PW = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              o_vld,
  input  logic              o_rdy,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [LEN_W-1:0] len_r, issued, beats;
  logic [ADDR_W-1:0] cur_addr;
  logic [RD_LAT-1:0] sr;
  logic [CW-1:0] inflight, fifo_cnt;
  logic [PW-1:0] wptr, rptr;
  logic [DATA_W-1:0] mem [FIFO_DEP];
  logic accept, flush, credit, wr, rd;
  assign accept = state == IDLE && start && !abort;
  assign flush = abort && (state == ISSUE || state == DRAIN);
  // a slot being drained this cycle is already free for a read landing RD_LAT cycles later
  assign credit = {1'b0, inflight} + {1'b0, fifo_cnt} < (CW+1)'(FIFO_DEP) + (CW+1)'(rd);
  assign rom_rd_en = state == ISSUE && !abort && issued < len_r && credit;
  assign rom_addr = cur_addr;
  assign wr = sr[RD_LAT-1];
  assign o_vld = fifo_cnt != '0;
  assign rd = o_vld && o_rdy;
  assign o_data = o_vld ? mem[rptr] : '0;
  assign o_last = o_vld && beats == len_r - LEN_W'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state == IDLE  ? (accept ? (len == '0 ? DONE : ISSUE) : IDLE)
        : state == DONE  ? IDLE
        : flush          ? DONE
        : state == ISSUE ? (rom_rd_en && issued == len_r - LEN_W'(1) ? DRAIN : ISSUE)
        : (rd && o_last ? DONE : DRAIN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_r <= '0;
      issued <= '0;
      beats <= '0;
      cur_addr <= '0;
      sr <= '0;
      inflight <= '0;
      fifo_cnt <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        len_r <= len;
        cur_addr <= base;
        issued <= '0;
        beats <= '0;
      end else begin
        if (rom_rd_en) begin
          cur_addr <= cur_addr == ADDR_W'(DEPTH - 1) ? '0 : cur_addr + ADDR_W'(1);
          issued <= issued + LEN_W'(1);
        end
        if (rd) beats <= beats + LEN_W'(1);
      end
      if (flush) begin
        sr <= '0;
        inflight <= '0;
        fifo_cnt <= '0;
        wptr <= '0;
        rptr <= '0;
      end else begin
        assert (!(wr && !rd && fifo_cnt == CW'(FIFO_DEP)));
        sr <= RD_LAT'({sr, rom_rd_en});
        inflight <= inflight + CW'(rom_rd_en) - CW'(wr);
        fifo_cnt <= fifo_cnt + CW'(wr) - CW'(rd);
        if (wr) wptr <= wptr == PW'(FIFO_DEP - 1) ? '0 : wptr + PW'(1);
        if (rd) rptr <= rptr == PW'(FIFO_DEP - 1) ? '0 : rptr + PW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wptr] <= rom_data;
  end
endmodule

// File: tb/tb_com_sprom_rd_stream.sv
// tb_com_sprom_rd_stream: directed checks of sweep, wrap, backpressure, abort and reset
module tb_com_sprom_rd_stream;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [5:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  logic start1 = 0, abort1 = 0, rdy1 = 0, busy1, done1, rd1, vld1, last1;
  logic [5:0] base1 = 0, addr1;
  logic [6:0] len1 = 0;
  logic [31:0] rdata1, data1;
  logic start3 = 0, abort3 = 0, rdy3 = 0, busy3, done3, rd3, vld3, last3;
  logic [5:0] base3 = 0, addr3;
  logic [6:0] len3 = 0;
  logic [31:0] rdata3, data3;
  logic [31:0] p3 [3];

  com_sprom_rd_stream u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .base(base1), .len(len1), .abort(abort1),
    .busy(busy1), .done(done1), .rom_rd_en(rd1), .rom_addr(addr1), .rom_data(rdata1),
    .o_vld(vld1), .o_rdy(rdy1), .o_data(data1), .o_last(last1));
  com_sprom_rd_stream #(.RD_LAT(3), .FIFO_DEP(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .base(base3), .len(len3), .abort(abort3),
    .busy(busy3), .done(done3), .rom_rd_en(rd3), .rom_addr(addr3), .rom_data(rdata3),
    .o_vld(vld3), .o_rdy(rdy3), .o_data(data3), .o_last(last3));

  always @(posedge clk) rdata1 <= rom(addr1);
  always @(posedge clk) begin
    p3[0] <= rom(addr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata3 = p3[2];

  logic [31:0] q1[$];
  logic l1[$];
  logic [5:0] a1[$];
  int rdn1, dn1, dcyc1, fv1, lx1, s1;
  always @(negedge clk) begin
    if (start1) begin
      q1.delete(); l1.delete(); a1.delete();
      rdn1 = 0; dn1 = 0; fv1 = -1; s1 = cyc + 1;
    end
    if (rd1) begin a1.push_back(addr1); rdn1++; end
    if (vld1 && fv1 < 0) fv1 = cyc;
    if (vld1 && rdy1) begin q1.push_back(data1); l1.push_back(last1); lx1 = cyc; end
    if (done1) begin dn1++; dcyc1 = cyc; end
  end

  logic [31:0] q3[$];
  logic l3[$];
  int rdn3, btn3, maxo3, uns3, dn3;
  logic pst = 0;
  logic [31:0] pd;
  always @(negedge clk) begin
    if (start3) begin
      q3.delete(); l3.delete();
      rdn3 = 0; btn3 = 0; maxo3 = 0; uns3 = 0; dn3 = 0; pst = 0;
    end
    if (pst && (!vld3 || data3 !== pd)) uns3++;
    pst = vld3 && !rdy3;
    pd = data3;
    if (rd3) rdn3++;
    if (vld3 && rdy3) begin q3.push_back(data3); l3.push_back(last3); btn3++; end
    if (rdn3 - btn3 > maxo3) maxo3 = rdn3 - btn3;
    if (done3) dn3++;
  end

  task automatic go1(input logic [5:0] b, input logic [6:0] l);
    @(posedge clk); #1 start1 = 1; base1 = b; len1 = l;
    @(posedge clk); #1 start1 = 0;
  endtask
  task automatic go3(input logic [5:0] b, input logic [6:0] l);
    @(posedge clk); #1 start3 = 1; base3 = b; len3 = l;
    @(posedge clk); #1 start3 = 0;
  endtask
  task automatic idle1(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    chk(tag, busy1, 0);
  endtask
  task automatic idle3(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy3) break;
    end
    chk(tag, busy3, 0);
  endtask

  initial begin
    logic [5:0] ea;
    int nl;
    repeat (3) @(posedge clk);
    #1;
    chk("rst1", {busy1, done1, rd1, vld1, last1, addr1, data1}, 0);
    chk("rst3", {busy3, done3, rd3, vld3, last3, addr3, data3}, 0);
    rst = 0;

    rdy1 = 1;
    go1(0, 8);
    idle1("t1 timeout");
    chk("t1 beats", q1.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1 data", q1[i], rom(6'(i)));
      chk("t1 last", l1[i], i == 7);
    end
    chk("t1 first_vld", fv1, s1 + 2);
    chk("t1 rate", lx1 - fv1, 7);
    chk("t1 done_cyc", dcyc1, lx1 + 1);
    chk("t1 done_cnt", dn1, 1);

    go1(60, 8);
    idle1("t2 timeout");
    chk("t2 beats", q1.size(), 8);
    for (int i = 0; i < 8; i++) begin
      ea = 6'(60 + i);
      chk("t2 addr", a1[i], ea);
      chk("t2 data", q1[i], rom(ea));
      chk("t2 last", l1[i], i == 7);
    end

    go1(0, 0);
    idle1("t4 timeout");
    chk("t4 reads", rdn1, 0);
    chk("t4 vld", fv1, -1);
    chk("t4 done_cnt", dn1, 1);
    chk("t4 done_cyc", dcyc1, s1);

    go3(0, 8);
    for (int i = 0; i < 300 && busy3; i++) begin
      rdy3 = (i % 3 == 0);
      @(posedge clk); #1;
    end
    chk("t3 timeout", busy3, 0);
    chk("t3 beats", q3.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3 data", q3[i], rom(6'(i)));
      chk("t3 last", l3[i], i == 7);
    end
    chk("t3 max_outstanding", maxo3, 4);
    chk("t3 stable", uns3, 0);
    chk("t3 done_cnt", dn3, 1);

    rdy3 = 1;
    go3(0, 16);
    for (int i = 0; i < 100 && q3.size() < 5; i++) @(negedge clk);
    chk("t5 five beats", q3.size() >= 5, 1);
    @(posedge clk); #1 abort3 = 1;
    @(posedge clk); #1 abort3 = 0;
    chk("t5 vld drop", vld3, 0);
    chk("t5 done", done3, 1);
    chk("t5 busy in done", busy3, 1);
    @(posedge clk); #1;
    chk("t5 busy drop", busy3, 0);
    chk("t5 done pulse", done3, 0);
    chk("t5 partial", q3.size() < 16, 1);
    nl = 0;
    foreach (q3[i]) begin
      chk("t5 data", q3[i], rom(6'(i)));
      nl += l3[i];
    end
    chk("t5 no last", nl, 0);
    go3(4, 2);
    idle3("t5b timeout");
    chk("t5b beats", q3.size(), 2);
    chk("t5b data0", q3[0], rom(4));
    chk("t5b data1", q3[1], rom(5));
    chk("t5b last", {l3[0], l3[1]}, 2'b01);

    rdy1 = 0;
    go1(0, 3);
    repeat (6) @(posedge clk);
    #1;
    chk("t6 vld pre", vld1, 1);
    chk("t6 busy pre", busy1, 1);
    #2 rst = 1;
    #1;
    chk("t6 async rst", {busy1, done1, rd1, vld1, last1, addr1, data1}, 0);
    @(posedge clk); #1 rst = 0;
    rdy1 = 1;
    go1(4, 2);
    idle1("t6 timeout");
    chk("t6 beats", q1.size(), 2);
    chk("t6 data0", q1[0], rom(4));
    chk("t6 data1", q1[1], rom(5));
    chk("t6 last", {l1[0], l1[1]}, 2'b01);
    chk("t6 done_cnt", dn1, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
